color_dwell_tracker: RTL



---
 rtl/color_pkg.sv | 25 ++
 rtl/dwell_fifo.sv | 55 +++++
 rtl/color_dwell_tracker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the colour dwell tracker.
// Colour codes match the upstream Color FSM output encoding.
package color_pkg;

    localparam logic [1:0] COLOR_BLUE = 2'h1;
    localparam logic [1:0] COLOR_RED  = 2'h2;

    localparam int CNT_WIDTH_DEF = 8;
    localparam int DROP_WIDTH    = 8;

    typedef enum logic {
        IDLE,
        TRACK
    } trk_state_e;

    typedef struct packed {
        logic [1:0]               color;
        logic [CNT_WIDTH_DEF-1:0] count;
    } dwell_rec_t;

    function automatic logic is_legal(input logic [1:0] code);
        return (code == COLOR_BLUE) || (code == COLOR_RED);
    endfunction

endpackage

// File: rtl/dwell_fifo.sv
// Small synchronous record FIFO; a push into a full FIFO is
// accepted when a pop retires the head in the same cycle.
module dwell_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             accept_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_q, rd_q;
    logic [AW:0]      wr_d, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign accept_o = do_push;

    assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    // Empty storage reads as zero so the consumer never sees stale data.
    assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/color_dwell_tracker.sv
// Measures how long each colour code is held and emits a
// {colour, dwell} record on every change or illegal code.
module color_dwell_tracker
    import color_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            color_in,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [1:0]            rec_color,
    output logic [CNT_WIDTH-1:0]  rec_count,
    output logic                  illegal_seen,
    output logic                  drop_seen,
    output logic [DROP_WIDTH-1:0] drop_cnt,
    input  logic                  clear
);

    typedef struct packed {
        logic [1:0]           color;
        logic [CNT_WIDTH-1:0] count;
    } rec_t;

    localparam int                  RW       = $bits(rec_t);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    trk_state_e           state_q;
    logic [1:0]           cur_color_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 illegal_q;
    logic                 drop_q;
    logic [DROP_WIDTH-1:0] drop_cnt_q;

    logic                 legal;
    logic                 push;
    logic                 illegal_ev;
    logic                 drop_ev;
    logic                 accept;
    logic                 full;
    logic                 empty;
    rec_t                 push_rec;
    rec_t                 head_rec;
    logic [DROP_WIDTH-1:0] drop_cnt_d;

    assign legal      = is_legal(color_in);
    assign push       = (state_q == TRACK) && (color_in != cur_color_q);
    assign illegal_ev = (state_q == TRACK) && !legal;
    assign drop_ev    = push && !accept;

    assign push_rec.color = cur_color_q;
    assign push_rec.count = cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_ev) begin
            if (clear) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clear) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_color_q <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (legal) begin
                        cur_color_q <= color_in;
                        cnt_q       <= 1;
                        state_q     <= TRACK;
                    end
                end
                TRACK: begin
                    if (color_in == cur_color_q) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (legal) begin
                        cur_color_q <= color_in;
                        cnt_q       <= 1;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A same-cycle event outranks clear.
            illegal_q  <= illegal_ev | (illegal_q & ~clear);
            drop_q     <= drop_ev | (drop_q & ~clear);
            drop_cnt_q <= drop_cnt_d;
        end
    end

    dwell_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .data_i   (push_rec),
        .pop_i    (rec_ready),
        .data_o   (head_rec),
        .full_o   (full),
        .empty_o  (empty),
        .accept_o (accept)
    );

    assign rec_valid    = !empty;
    assign rec_color    = head_rec.color;
    assign rec_count    = head_rec.count;
    assign illegal_seen = illegal_q;
    assign drop_seen    = drop_q;
    assign drop_cnt     = drop_cnt_q;

    logic unused_full;
    assign unused_full = full;

endmodule
